// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: owns receiver line config, drains characters into a FIFO, raises irq.
// Define UART_RX_CTRL_ERR_DROP_EN to drop parity/break characters and count them.
module uart_rx_ctrl #(
  parameter int DIV_W      = 24,
  parameter int DEPTH_LOG2 = 4,
  parameter int TMO_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [DIV_W+5:0]      cfg_in,
  output logic                  cfg_pending,
  output logic [1:0]            cfg_data_bits,
  output logic                  cfg_has_parity,
  output logic [1:0]            cfg_parity_mode,
  output logic                  cfg_extra_stop,
  output logic [DIV_W-1:0]      cfg_divisor,
  input  logic                  rx_busy,
  input  logic [8:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_parity_err,
  input  logic                  rx_overflow,
  input  logic                  rx_break,
  output logic                  rx_ack,
  input  logic                  rd_en,
  output logic [11:0]           rd_data,
  output logic                  rd_empty,
  output logic [DEPTH_LOG2:0]   level,
  input  logic [DEPTH_LOG2:0]   thresh,
  input  logic [TMO_W-1:0]      tmo_limit,
  output logic                  fifo_ovf,
  input  logic                  ovf_clr,
`ifdef UART_RX_CTRL_ERR_DROP_EN
  output logic [15:0]           err_drop_cnt,
`endif
  output logic                  irq
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL =
    (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE =
    (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE =
    (DEPTH_LOG2)'(1);
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_CAPT,
    S_ACKW
  } state_t;

  state_t state;

  logic [DIV_W+5:0]      shadow;
  logic [11:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [TMO_W-1:0]      tmo_cnt;

  logic        empty;
  logic        full;
  logic        capt;
  logic        pop;
  logic        push;
  logic        loss;
  logic        drop;
  logic        apply;
  logic        tmo_hit;
  logic [11:0] char_in;

  assign empty   = level == '0;
  assign full    = level == FULL;
  assign capt    = state == S_CAPT;
  assign pop     = rd_en && !empty;
  assign char_in = {rx_break, rx_overflow,
                    rx_parity_err, rx_data};

`ifdef UART_RX_CTRL_ERR_DROP_EN
  assign drop = capt && (rx_parity_err || rx_break);
`else
  assign drop = 1'b0;
`endif

  // A full FIFO still accepts when the host pops in the same cycle
  assign push = capt && !drop && (!full || rd_en);
  assign loss = capt && !drop && full && !rd_en;

  // Config only moves between characters so the receiver never sees a change mid-frame
  assign apply = cfg_pending && !rx_busy &&
                 (state == S_WAIT) && !rx_valid;

  assign tmo_hit = (tmo_limit != '0) &&
                   (tmo_cnt == tmo_limit);

  assign rd_empty = empty;
  assign rd_data  = empty ? 12'h000 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= char_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_WAIT;
      rx_ack          <= 1'b0;
      shadow          <= '0;
      cfg_pending     <= 1'b0;
      cfg_data_bits   <= 2'd0;
      cfg_has_parity  <= 1'b0;
      cfg_parity_mode <= 2'd0;
      cfg_extra_stop  <= 1'b0;
      cfg_divisor     <= DIV_W'(1);
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      tmo_cnt         <= '0;
      fifo_ovf        <= 1'b0;
      irq             <= 1'b0;
    end else begin
      unique case (state)
        S_WAIT:  if (rx_valid) state <= S_CAPT;
        S_CAPT:  state <= S_ACKW;
        S_ACKW:  if (!rx_valid) state <= S_WAIT;
        default: state <= S_WAIT;
      endcase

      rx_ack <= (state == S_WAIT) && rx_valid;

      if (apply) begin
        {cfg_data_bits, cfg_has_parity,
         cfg_parity_mode, cfg_extra_stop,
         cfg_divisor} <= shadow;
      end

      if (cfg_wr) begin
        shadow      <= cfg_in;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      if (push && !pop)
        level <= level + LVL_ONE;
      else if (pop && !push)
        level <= level - LVL_ONE;

      if (push || pop || empty)
        tmo_cnt <= '0;
      else if (tmo_cnt < tmo_limit)
        tmo_cnt <= tmo_cnt + TMO_ONE;
      else
        tmo_cnt <= tmo_limit;

      if (loss)
        fifo_ovf <= 1'b1;
      else if (ovf_clr)
        fifo_ovf <= 1'b0;

      irq <= ((thresh != '0) && (level >= thresh)) ||
             tmo_hit || fifo_ovf;
    end
  end

`ifdef UART_RX_CTRL_ERR_DROP_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_drop_cnt <= 16'd0;
    else if (drop && (err_drop_cnt != 16'hFFFF))
      err_drop_cnt <= err_drop_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller in front of the UART receiver. Owns the receiver's line configuration: data bits, parity, stop bits and clock divisor.
- Drains each received character with its status flags into a local FIFO and returns the acknowledge pulse to the receiver.
- Raises an interrupt when the FIFO reaches a fill threshold, or on an idle timeout while the FIFO holds data.
- Sits between the receiver and the host register interface.

Parameters:
- DIV_W, 24, clock divisor width; must match the receiver's divisor width.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries.
- TMO_W, 16, idle-timeout counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_wr  in  1  one-cycle pulse; stage new configuration
- cfg_in  in  6+DIV_W  {data_bits[1:0], has_parity, parity_mode[1:0], extra_stop, divisor}
- cfg_pending  out  1  staged configuration not yet applied
- cfg_data_bits  out  2  to receiver
- cfg_has_parity  out  1  to receiver
- cfg_parity_mode  out  2  to receiver
- cfg_extra_stop  out  1  to receiver
- cfg_divisor  out  DIV_W  to receiver
- rx_busy  in  1  receiver is not idle
- rx_data  in  9  receiver character
- rx_valid  in  1  receiver dataReceived
- rx_parity_err  in  1  from receiver
- rx_overflow  in  1  from receiver
- rx_break  in  1  from receiver
- rx_ack  out  1  one-cycle acknowledge to receiver (receiveData)
- rd_en  in  1  host pop
- rd_data  out  12  {break, overflow, parity_err, data[8:0]} of FIFO head
- rd_empty  out  1  FIFO empty
- level  out  DEPTH_LOG2+1  FIFO occupancy
- thresh  in  DEPTH_LOG2+1  interrupt fill threshold
- tmo_limit  in  TMO_W  idle-timeout in clk cycles; 0 disables
- fifo_ovf  out  1  sticky; a character was lost to a full FIFO
- ovf_clr  in  1  clears fifo_ovf
- irq  out  1  level interrupt

Behaviour:
- Reset state:
  - All cfg_* outputs 0; cfg_divisor = 1.
  - cfg_pending, rx_ack, fifo_ovf, irq = 0.
  - FIFO empty: level = 0, rd_empty = 1, rd_data = 0.
  - Timeout counter = 0. FSM in S_WAIT.
- Config staging:
  - cfg_wr loads the shadow register and sets cfg_pending.
  - A second cfg_wr while pending overwrites the shadow; last write wins.
- Config apply:
  - Shadow is copied to the cfg_* outputs on the first cycle with cfg_pending=1, rx_busy=0, FSM in S_WAIT and rx_valid=0.
  - cfg_pending clears in that same cycle.
  - The receiver never sees a change mid-character.
- Capture FSM:
  - S_WAIT: on rx_valid=1, go to S_CAPT.
  - S_CAPT, one cycle:
    - Push {rx_break, rx_overflow, rx_parity_err, rx_data} if not full, or if full with rd_en=1 in the same cycle (pop and push together).
    - Otherwise discard the character and set fifo_ovf.
    - Assert rx_ack. Go to S_ACKW.
  - S_ACKW: wait for rx_valid=0, then return to S_WAIT.
  - Capture latency: rx_valid rising to entry visible on rd_data (if FIFO was empty) = 2 cycles.
- FIFO:
  - Circular pointers with wrap-around at DEPTH.
  - rd_data shows the head combinationally from registered storage.
  - rd_en while empty is ignored; level unchanged.
  - Simultaneous push and pop: level unchanged.
- Timeout:
  - Counter resets on every push, every pop, and whenever the FIFO is empty.
  - Otherwise it increments, saturating at tmo_limit.
  - tmo_hit = (tmo_limit != 0) && (counter == tmo_limit).
- irq = (level >= thresh && thresh != 0) || tmo_hit || fifo_ovf. Registered: 1-cycle delay after the cause.
- fifo_ovf: ovf_clr in the same cycle as a new loss leaves it set (set wins).
- Reset mid-character: all state clears. The receiver's pending dataReceived is re-captured after reset once rx_valid is still high.

Optional Feature:
- Macro: UART_RX_CTRL_ERR_DROP_EN.
- Defined:
  - Characters with parity_err=1 or break=1 are acked but not pushed.
  - A 16-bit saturating output err_drop_cnt counts them; reset 0.
- Undefined:
  - All characters are pushed with their flags.
  - err_drop_cnt port is absent.

Test Plan:
- Reset, then cfg_wr with data_bits=3, has_parity=1, divisor=0x000010 while rx_busy=1 -> cfg_pending=1 and outputs unchanged; rx_busy drops -> outputs update in 1 cycle, cfg_pending=0.
- Receiver delivers 0x055 -> rx_ack pulses once; 2 cycles later rd_empty=0, rd_data=0x055, level=1.
- thresh=4, deliver 4 characters -> irq rises 1 cycle after level=4; pop one -> irq falls.
- Fill 16 entries, deliver a 17th -> rx_ack still pulses, fifo_ovf=1, level=16, head unchanged; ovf_clr -> fifo_ovf=0.
- tmo_limit=100, one character, no reads -> irq asserts 101 cycles after the push; pop -> counter clears, irq=0.
- Character with rx_break=1: macro undefined -> rd_data[11]=1; macro defined -> rd_empty stays 1, err_drop_cnt=1.
